// File: rtl/mat_bram_ctrl.sv
// mat_bram_ctrl: slot-addressed matrix store over a single-port inferred RAM, one beat of rows per cycle.
//   I_CLK, I_RST_N      : clock (rising edge), asynchronous active-low reset
//   I_REQ_VLD/O_REQ_RDY : request handshake, ready only while idle
//   I_REQ_WR            : 1 = write matrix, 0 = read matrix
//   I_REQ_SLOT          : target matrix slot; slots >= NUM_SLOTS are rejected with O_ERR
//   I_BEAT_EN           : per-beat enable, bit b covers rows b*BEAT_ROWS .. b*BEAT_ROWS+BEAT_ROWS-1
//   I_WR_MAT            : write matrix, captured at acceptance
//   O_RD_VLD, O_RD_MAT  : read-complete pulse and the read matrix register
//   O_WR_DONE, O_ERR    : write-complete pulse and rejected-slot pulse
module mat_bram_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ROWS      = 16,
    parameter int COLS      = 128,
    parameter int BEAT_ROWS = 4,
    parameter int NUM_SLOTS = 256,
    parameter int SLOT_W    = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                                     I_CLK,
    input  logic                                     I_RST_N,
    input  logic                                     I_REQ_VLD,
    output logic                                     O_REQ_RDY,
    input  logic                                     I_REQ_WR,
    input  logic [SLOT_W-1:0]                        I_REQ_SLOT,
    input  logic [ROWS/BEAT_ROWS-1:0]                I_BEAT_EN,
    input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]    I_WR_MAT,
    output logic                                     O_RD_VLD,
    output logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]    O_RD_MAT,
    output logic                                     O_WR_DONE,
    output logic                                     O_ERR
);
    localparam int BEATS  = ROWS / BEAT_ROWS;
    localparam int WORD_W = BEAT_ROWS * COLS * DATA_W;
    localparam int MAT_W  = ROWS * COLS * DATA_W;
    localparam int DEPTH  = NUM_SLOTS * BEATS;
    localparam int AW     = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int BW     = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [SLOT_W-1:0]   slot_q;
    logic [BEATS-1:0]    en_q;
    logic [MAT_W-1:0]    wmat_q, rd_mat_q;
    logic                rd_vld_q, wr_done_q, err_q;
    logic [RD_LAT-1:0]   tag_vld_q, tag_en_q;
    logic [BW-1:0]       tag_beat_q [RD_LAT];
    logic [WORD_W-1:0]   pipe_q [RD_LAT];
    logic [WORD_W-1:0]   ram [DEPTH];
    logic                accept, bad_slot, ram_we, ram_re, last_ret;
    logic [AW-1:0]       addr;

    // Flat layout of the matrix equals the RAM word layout, so beat b is a plain slice.
    assign O_REQ_RDY = state_q == IDLE;
    assign O_RD_MAT  = rd_mat_q;
    assign O_RD_VLD  = rd_vld_q;
    assign O_WR_DONE = wr_done_q;
    assign O_ERR     = err_q;
    assign accept    = I_REQ_VLD & O_REQ_RDY;
    assign bad_slot  = {1'b0, I_REQ_SLOT} >= (SLOT_W+1)'(NUM_SLOTS);
    assign addr      = AW'(slot_q) * AW'(BEATS) + AW'(beat_q);
    assign ram_we    = state_q == WR && en_q[beat_q];
    assign ram_re    = state_q == RD_ISSUE;
    // The final beat emerging from the tag pipeline marks read completion.
    assign last_ret  = tag_vld_q[RD_LAT-1] && tag_beat_q[RD_LAT-1] == LAST;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (accept && !bad_slot) begin
                state_d = I_REQ_WR ? WR : RD_ISSUE;
                beat_d  = '0;
            end
            WR: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST) state_d = IDLE;
            end
            RD_ISSUE: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST) state_d = RD_DRAIN;
            end
            RD_DRAIN: if (last_ret) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            slot_q    <= '0;
            en_q      <= '0;
            rd_mat_q  <= '0;
            rd_vld_q  <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
            tag_vld_q <= '0;
            tag_en_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_beat_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            err_q     <= accept && bad_slot;
            wr_done_q <= state_q == WR && beat_q == LAST;
            rd_vld_q  <= last_ret;
            if (accept) begin
                slot_q <= I_REQ_SLOT;
                en_q   <= I_BEAT_EN;
            end
            tag_vld_q[0]  <= ram_re;
            tag_en_q[0]   <= en_q[beat_q];
            tag_beat_q[0] <= beat_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_en_q[i]   <= tag_en_q[i-1];
                tag_beat_q[i] <= tag_beat_q[i-1];
            end
            // Masked beats leave their rows untouched: partial refresh of the read register.
            if (tag_vld_q[RD_LAT-1] && tag_en_q[RD_LAT-1])
                rd_mat_q[int'(tag_beat_q[RD_LAT-1])*WORD_W +: WORD_W] <= pipe_q[RD_LAT-1];
        end
    end

    // RAM and its read-data pipeline carry no reset; only the tags decide what is used.
    always_ff @(posedge I_CLK) begin
        if (accept && I_REQ_WR) wmat_q <= I_WR_MAT;
        if (ram_we) ram[addr] <= wmat_q[int'(beat_q)*WORD_W +: WORD_W];
        if (ram_re) pipe_q[0] <= ram[addr];
        for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
endmodule

// File: tb/tb_mat_bram_ctrl.sv
// tb_mat_bram_ctrl: table-driven scoreboard bench for mat_bram_ctrl (default instance and a 200-slot, RD_LAT=3 instance).
module tb_mat_bram_ctrl;
    typedef logic [15:0][127:0][7:0] mat_t;
    typedef struct {
        bit         b;
        bit         wr;
        logic [7:0] slot;
        logic [3:0] en;
        bit         ramp;
        logic [7:0] fill;
        int         lat;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0, vld_a = 1'b0, vld_b = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] slot = '0;
    logic [3:0] en = '0;
    mat_t       wmat = '0;
    logic       rdy_a, rd_vld_a, done_a, err_a, rdy_b, rd_vld_b, done_b, err_b;
    mat_t       rd_mat_a, rd_mat_b;

    mat_t mem_a [256];
    mat_t mem_b [256];
    mat_t rd_a = '0, rd_b = '0;
    mat_t q_a [$];
    mat_t q_b [$];
    int   n_cmp = 0, n_bad = 0;
    op_t  tbl [15];

    always #5 clk = ~clk;

    mat_bram_ctrl u_a (
        .I_CLK(clk), .I_RST_N(rst_a), .I_REQ_VLD(vld_a), .O_REQ_RDY(rdy_a), .I_REQ_WR(wr),
        .I_REQ_SLOT(slot), .I_BEAT_EN(en), .I_WR_MAT(wmat), .O_RD_VLD(rd_vld_a),
        .O_RD_MAT(rd_mat_a), .O_WR_DONE(done_a), .O_ERR(err_a)
    );

    mat_bram_ctrl #(.NUM_SLOTS(200), .RD_LAT(3)) u_b (
        .I_CLK(clk), .I_RST_N(rst_b), .I_REQ_VLD(vld_b), .O_REQ_RDY(rdy_b), .I_REQ_WR(wr),
        .I_REQ_SLOT(slot), .I_BEAT_EN(en), .I_WR_MAT(wmat), .O_RD_VLD(rd_vld_b),
        .O_RD_MAT(rd_mat_b), .O_WR_DONE(done_b), .O_ERR(err_b)
    );

    function automatic mat_t mk(input bit ramp, input logic [7:0] f);
        mat_t m;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 128; c++)
                m[r][c] = ramp ? 8'(r * 8 + c) : f;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_mat(input string nm, input mat_t act, input mat_t exp);
        bit shown = 0;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 128; c++)
                    if (!shown && act[r][c] !== exp[r][c]) begin
                        shown = 1;
                        $display("FAIL %s: element [%0d][%0d] got %0h expected %0h", nm, r, c, act[r][c], exp[r][c]);
                    end
        end
    endtask

    // Scoreboard: every read completion pops the matrix predicted at acceptance.
    always @(negedge clk) begin
        if (rd_vld_a) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_vld_a: got unexpected pulse, expected none");
            end else chk_mat("rd_mat_a", rd_mat_a, q_a.pop_front());
        end
        if (rd_vld_b) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_vld_b: got unexpected pulse, expected none");
            end else chk_mat("rd_mat_b", rd_mat_b, q_b.pop_front());
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge where the completion pulse is due.
    task automatic run_op(input op_t o);
        mat_t m;
        bit   bad;
        int   first;
        logic p, rdy;
        m = mk(o.ramp, o.fill);
        wr = o.wr; slot = o.slot; en = o.en; wmat = m;
        if (o.b) vld_b = 1'b1; else vld_a = 1'b1;
        @(posedge clk);
        bad = o.slot >= (o.b ? 200 : 256);
        if (!bad) begin
            for (int bt = 0; bt < 4; bt++)
                if (o.en[bt])
                    for (int r = bt * 4; r < bt * 4 + 4; r++) begin
                        if (o.wr && o.b) mem_b[o.slot][r] = m[r];
                        else if (o.wr) mem_a[o.slot][r] = m[r];
                        else if (o.b) rd_b[r] = mem_b[o.slot][r];
                        else rd_a[r] = mem_a[o.slot][r];
                    end
            if (!o.wr && o.b) q_b.push_back(rd_b);
            else if (!o.wr) q_a.push_back(rd_a);
        end
        #1;
        vld_a = 1'b0; vld_b = 1'b0; wmat = ~m;
        first = -1;
        for (int k = 0; k <= o.lat; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            p   = bad ? (o.b ? err_b : err_a) : o.wr ? (o.b ? done_b : done_a) : (o.b ? rd_vld_b : rd_vld_a);
            rdy = o.b ? rdy_b : rdy_a;
            if (k == 0) chk("rdy_after_accept", 32'(rdy), 32'(o.lat == 0));
            if (p && first < 0) first = k;
        end
        chk(bad ? "err_latency" : o.wr ? "wr_done_latency" : "rd_vld_latency", first, o.lat);
        chk("rdy_at_completion", 32'(o.b ? rdy_b : rdy_a), 1);
    endtask

    initial begin
        int hits;
        tbl[0]  = '{0, 1, 8'd3,   4'hF,    1, 8'h00, 4};
        tbl[1]  = '{0, 0, 8'd3,   4'hF,    0, 8'h00, 6};
        tbl[2]  = '{0, 1, 8'd0,   4'hF,    0, 8'hAA, 4};
        tbl[3]  = '{0, 1, 8'd1,   4'hF,    0, 8'h55, 4};
        tbl[4]  = '{0, 0, 8'd0,   4'hF,    0, 8'h00, 6};
        tbl[5]  = '{0, 1, 8'd2,   4'hF,    0, 8'h11, 4};
        tbl[6]  = '{0, 1, 8'd2,   4'b0101, 0, 8'h22, 4};
        tbl[7]  = '{0, 0, 8'd2,   4'hF,    0, 8'h00, 6};
        tbl[8]  = '{0, 0, 8'd0,   4'b0001, 0, 8'h00, 6};
        tbl[9]  = '{0, 0, 8'd3,   4'h0,    0, 8'h00, 6};
        tbl[10] = '{0, 1, 8'd1,   4'h0,    0, 8'hFF, 4};
        tbl[11] = '{0, 0, 8'd1,   4'hF,    0, 8'h00, 6};
        tbl[12] = '{1, 1, 8'd3,   4'hF,    1, 8'h00, 4};
        tbl[13] = '{1, 1, 8'd250, 4'hF,    0, 8'hFF, 0};
        tbl[14] = '{1, 0, 8'd3,   4'hF,    0, 8'h00, 7};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_vld", 32'(rd_vld_a), 0);
        chk("reset_wr_done", 32'(done_a), 0);
        chk("reset_err", 32'(err_a), 0);
        chk_mat("reset_rd_mat", rd_mat_a, '0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rdy", 32'(rdy_a), 1);

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i]);
            if (i == 1) chk("rd_mat_5_7", 32'(rd_mat_a[5][7]), 47);
        end
        @(posedge clk);
        #1;
        chk("rd_vld_b_single_cycle", 32'(rd_vld_b), 0);

        // Reset one cycle into a read: the read is abandoned without a valid pulse.
        wr = 1'b0; slot = 8'd3; en = 4'hF; vld_b = 1'b1;
        @(posedge clk);
        #1;
        vld_b = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        chk("midrst_rd_vld", 32'(rd_vld_b), 0);
        chk("midrst_wr_done", 32'(done_b), 0);
        chk("midrst_err", 32'(err_b), 0);
        chk_mat("midrst_rd_mat", rd_mat_b, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        rd_b = '0;
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (rd_vld_b) hits++;
        end
        chk("postrst_rd_vld_count", hits, 0);
        chk("postrst_rdy", 32'(rdy_b), 1);
        run_op('{1, 0, 8'd3, 4'hF, 0, 8'h00, 7});
        @(posedge clk);
        #1;
        chk("final_queue_a", q_a.size(), 0);
        chk("final_queue_b", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
